// File: rtl/filter_load_ctrl_pkg.sv
// Shared types for the filter load controller: FSM states, chunk count, chunk-to-enable mapping.
// Optional FILTER_LOAD_PERF_EN build adds a stall counter in the top module; nothing here changes.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int BUF_BYTES_DEF  = 16;
    localparam int WORD_BYTES_DEF = 4;
    localparam int CHUNKS         = BUF_BYTES_DEF / WORD_BYTES_DEF;

    // Chunk c lands at bytes c*W..c*W+W-1; the buffer counts enables from the MSB down.
    function automatic int chunk_en_bit(input int chunk, input int buf_bytes, input int word_bytes);
        return buf_bytes - 1 - chunk * word_bytes;
    endfunction

endpackage

// File: rtl/filter_load_ctrl_if.sv
// Control, memory-read and buffer-side signals of the filter load controller.
// master = controller, slave = surroundings (CNN controller, memory port, buffer, conv engine).
interface filter_load_ctrl_if #(
    parameter int ADDR_W    = 16,
    parameter int BUF_BYTES = 16,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [CNT_W-1:0]     num_filters;
    logic                 busy;
    logic                 done;
    logic                 rd_req;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_valid;
    logic [BUF_BYTES-1:0] buf_en;
    logic                 filt_ready;
    logic                 filt_consume;
    logic [CNT_W-1:0]     filt_idx;

    modport master (
        input  start, base_addr, num_filters, rd_valid, filt_consume,
        output busy, done, rd_req, rd_addr, buf_en, filt_ready, filt_idx
    );

    modport slave (
        output start, base_addr, num_filters, rd_valid, filt_consume,
        input  busy, done, rd_req, rd_addr, buf_en, filt_ready, filt_idx
    );
endinterface

// File: rtl/filter_load_ctrl.sv
// Loads num_filters filters chunk by chunk into the filter buffer and holds each until consumed.
// rd_req one cycle after start; buf_en is Mealy on rd_valid. FILTER_LOAD_PERF_EN adds stall_cycles.
module filter_load_ctrl
    import filter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int BUF_BYTES  = BUF_BYTES_DEF,
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    filter_load_ctrl_if.master bus
`ifdef FILTER_LOAD_PERF_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    localparam int NCHUNK  = BUF_BYTES / WORD_BYTES;
    localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e               r_state;
    logic [CHUNK_W-1:0]   r_chunk;
    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_num;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_req;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_beat;
    logic                 w_last_chunk;
    logic                 w_last_filt;
    logic [BUF_BYTES-1:0] w_buf_en;

    assign w_beat       = (r_state == LOAD) && bus.rd_valid;
    assign w_last_chunk = (r_chunk == CHUNK_W'(NCHUNK - 1));
    assign w_last_filt  = (r_idx == (r_num - 1'b1));

    always_comb begin
        w_buf_en = '0;
        if (w_beat) begin
            w_buf_en = {{(BUF_BYTES-1){1'b0}}, 1'b1} << chunk_en_bit(int'(r_chunk), BUF_BYTES, WORD_BYTES);
        end
    end

    // Filters are stored back to back, so base+idx*CHUNKS+chunk is just a running word address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_chunk <= '0;
            r_idx   <= '0;
            r_num   <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_num   <= bus.num_filters;
                        r_addr  <= bus.base_addr;
                        r_idx   <= '0;
                        r_chunk <= '0;
                        r_busy  <= 1'b1;
                        if (bus.num_filters == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                            r_req   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.rd_valid) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_last_chunk) begin
                            r_chunk <= '0;
                            r_req   <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= FULL;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.filt_consume) begin
                        r_ready <= 1'b0;
                        if (w_last_filt) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_req   <= 1'b1;
                            r_state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FILTER_LOAD_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_stall <= '0;
        end else if (r_req && !bus.rd_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rd_req     = r_req;
    assign bus.rd_addr    = r_addr;
    assign bus.buf_en     = w_buf_en;
    assign bus.filt_ready = r_ready;
    assign bus.filt_idx   = r_idx;

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl: job-level reference model compared every cycle plus literal pins.
module tb_filter_load_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_load_ctrl_if #(.ADDR_W(16), .BUF_BYTES(16), .CNT_W(8)) fi ();

`ifdef FILTER_LOAD_PERF_EN
    logic [15:0] stall_cycles;
`endif

    filter_load_ctrl #(.ADDR_W(16), .BUF_BYTES(16), .WORD_BYTES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fi.master)
`ifdef FILTER_LOAD_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Job-level model: a job is n filters of 4 beats; beat k reads base+k into bytes 4*(k%4).
    int          m_active = 0;
    int          m_done   = 0;
    int          m_n      = 0;
    int          m_beats  = 0;
    int          m_cons   = 0;
    logic [15:0] m_base   = '0;
    bit          m_idle;
    bit          m_load;
    bit          m_rdy;

    function automatic bit mdl_loading();
        return (m_active != 0) && (m_beats < 4 * (m_cons + 1));
    endfunction

    function automatic bit mdl_ready();
        return (m_active != 0) && (m_beats == 4 * (m_cons + 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_done   = 0;
            m_beats  = 0;
            m_cons   = 0;
        end else begin
            m_idle = (m_active == 0) && (m_done == 0);
            m_load = mdl_loading();
            m_rdy  = mdl_ready();
            m_done = 0;
            if (m_idle) begin
                if (fi.start) begin
                    m_base  = fi.base_addr;
                    m_n     = int'(fi.num_filters);
                    m_beats = 0;
                    m_cons  = 0;
                    if (m_n == 0) m_done = 1;
                    else          m_active = 1;
                end
            end else if (m_load && fi.rd_valid) begin
                m_beats++;
            end else if (m_rdy && fi.filt_consume) begin
                m_cons++;
                if (m_cons == m_n) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    end

    logic [15:0] e_addr;
    logic [15:0] e_en;
    int          e_idx;

    always @(negedge clk) begin
        e_addr = m_base + 16'(m_beats);
        e_en   = (mdl_loading() && fi.rd_valid) ? (16'h0001 << (15 - 4 * (m_beats % 4))) : 16'h0000;
        e_idx  = (m_active != 0) ? m_cons : ((m_done != 0 && m_n > 0) ? m_n - 1 : 0);
        check("busy",       32'(fi.busy),       32'((m_active != 0) || (m_done != 0)));
        check("done",       32'(fi.done),       32'(m_done != 0));
        check("rd_req",     32'(fi.rd_req),     32'(mdl_loading()));
        if (mdl_loading()) check("rd_addr", 32'(fi.rd_addr), 32'(e_addr));
        check("buf_en",     32'(fi.buf_en),     32'(e_en));
        check("filt_ready", 32'(fi.filt_ready), 32'(mdl_ready()));
        check("filt_idx",   32'(fi.filt_idx),   32'(e_idx));
    end

    logic [15:0] rec_addr[$];
    logic [15:0] rec_en[$];
    int          rdy_idx[$];
    int          done_cnt;
    bit          req_seen;

    always @(negedge clk) begin
        if (rst_n && fi.rd_req && fi.rd_valid) begin
            rec_addr.push_back(fi.rd_addr);
            rec_en.push_back(fi.buf_en);
        end
        if (rst_n && fi.done) done_cnt++;
    end

    task automatic run_job(input logic [15:0] base, input logic [7:0] n, input int gap,
                           input int cdly, input int spur,
                           output int first_rdy, output int done_cyc, output int busy_cyc);
        int age;
        bit fin;
        rec_addr.delete();
        rec_en.delete();
        rdy_idx.delete();
        done_cnt  = 0;
        req_seen  = 0;
        first_rdy = 0;
        done_cyc  = 0;
        busy_cyc  = 0;
        age       = 0;
        fin       = 0;
        fi.base_addr    = base;
        fi.num_filters  = n;
        fi.start        = 1'b1;
        fi.rd_valid     = 1'b0;
        fi.filt_consume = 1'b0;
        step();
        fi.start = 1'b0;
        for (int i = 1; i <= 600 && !fin; i++) begin
            if (fi.filt_ready) begin
                age++;
                if (age == 1) begin
                    rdy_idx.push_back(int'(fi.filt_idx));
                    if (first_rdy == 0) first_rdy = i;
                end
            end else begin
                age = 0;
            end
            if (fi.busy)   busy_cyc++;
            if (fi.rd_req) req_seen = 1;
            if (fi.done) begin
                done_cyc = i;
                fin      = 1;
            end
            fi.rd_valid     = (gap == 0) ? 1'b1 : (((i - 1) % (gap + 1)) == gap);
            fi.filt_consume = (age == cdly + 1);
            fi.start        = (i == spur);
            if (i == spur) fi.base_addr = 16'h0AAA;
            step();
        end
        if (!fin) check("job_timeout", 32'd0, 32'd1);
        fi.rd_valid     = 1'b0;
        fi.filt_consume = 1'b0;
        fi.start        = 1'b0;
    endtask

    logic [15:0] t1_en [4] = '{16'h8000, 16'h0800, 16'h0080, 16'h0008};
    logic [15:0] t5_a  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fr, dc, bc;
        fi.start        = 1'b0;
        fi.base_addr    = '0;
        fi.num_filters  = '0;
        fi.rd_valid     = 1'b0;
        fi.filt_consume = 1'b0;
        repeat (3) step();
        check("rst_busy",  32'(fi.busy),     32'd0);
        check("rst_rdreq", 32'(fi.rd_req),   32'd0);
        check("rst_idx",   32'(fi.filt_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // single filter, back-to-back data
        run_job(16'h0100, 8'd1, 0, 0, 0, fr, dc, bc);
        check("t1_nbeats", 32'(rec_addr.size()), 32'd4);
        for (int k = 0; k < rec_addr.size() && k < 4; k++) begin
            check("t1_addr", 32'(rec_addr[k]), 32'h100 + 32'(k));
            check("t1_en",   32'(rec_en[k]),   32'(t1_en[k]));
        end
        check("t1_ready_cyc", 32'(fr), 32'd5);
        repeat (3) step();
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // three filters, delayed consume, ignored start mid-job
        run_job(16'h0100, 8'd3, 0, 2, 3, fr, dc, bc);
        check("t2_nbeats", 32'(rec_addr.size()), 32'd12);
        if (rec_addr.size() == 12) check("t2_last_addr", 32'(rec_addr[11]), 32'h10B);
        check("t2_nready", 32'(rdy_idx.size()), 32'd3);
        for (int k = 0; k < rdy_idx.size() && k < 3; k++)
            check("t2_filt_idx", 32'(rdy_idx[k]), 32'(k));
        repeat (3) step();
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // gapped read data, one valid in three cycles
        run_job(16'h0040, 8'd1, 2, 0, 0, fr, dc, bc);
        check("t3_nbeats", 32'(rec_addr.size()), 32'd4);
        if (rec_en.size() == 4) check("t3_en3", 32'(rec_en[3]), 32'h0008);
        check("t3_ready_cyc", 32'(fr), 32'd13);
`ifdef FILTER_LOAD_PERF_EN
        check("t3_stall", 32'(stall_cycles), 32'd8);
`endif
        repeat (2) step();

        // empty job
        run_job(16'h0300, 8'd0, 0, 0, 0, fr, dc, bc);
        check("t4_done_cyc", 32'(dc), 32'd1);
        check("t4_busy_cyc", 32'(bc), 32'd1);
        check("t4_req_seen", 32'(req_seen), 32'd0);
        step();
        check("t4_idle", 32'(fi.busy), 32'd0);

        // address wrap
        run_job(16'hFFFE, 8'd1, 0, 0, 0, fr, dc, bc);
        check("t5_nbeats", 32'(rec_addr.size()), 32'd4);
        for (int k = 0; k < rec_addr.size() && k < 4; k++)
            check("t5_addr", 32'(rec_addr[k]), 32'(t5_a[k]));
        repeat (2) step();

        // asynchronous reset after the second beat, stale rd_valid, then reload
        fi.base_addr   = 16'h0200;
        fi.num_filters = 8'd1;
        fi.start       = 1'b1;
        step();
        fi.start    = 1'b0;
        fi.rd_valid = 1'b1;
        step();
        step();
        check("t6_pre_req", 32'(fi.rd_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req",  32'(fi.rd_req),  32'd0);
        check("t6_async_busy", 32'(fi.busy),    32'd0);
        check("t6_async_en",   32'(fi.buf_en),  32'd0);
        check("t6_async_addr", 32'(fi.rd_addr), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t6_stale_req", 32'(fi.rd_req), 32'd0);
        fi.rd_valid = 1'b0;
        run_job(16'h0200, 8'd1, 0, 0, 0, fr, dc, bc);
        check("t6_nbeats", 32'(rec_addr.size()), 32'd4);
        if (rec_addr.size() == 4) begin
            check("t6_addr0", 32'(rec_addr[0]), 32'h200);
            check("t6_en0",   32'(rec_en[0]),   32'h8000);
        end
        check("t6_ready_cyc", 32'(fr), 32'd5);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
